// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction ROM and buffers returned
// words in a 2-entry queue presented to decode over a valid/ready handshake.
module instr_fetch_unit #(
   parameter int          ADDR_BITS = 4,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic [ADDR_BITS-1:0] rom_addr,
   output logic                 rom_sel,
   input  logic [31:0]          rom_dout,
   input  logic                 redirect,
   input  logic [31:0]          redirect_pc,
   input  logic                 halt,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_instr,
   output logic [31:0]          out_pc,
   output logic                 halted
);

   typedef enum logic {RUN, HALTED} state_t;

   state_t      state;
   logic [31:0] pc;
   logic [1:0]  count;
   logic [31:0] head_instr, head_pc;
   logic [31:0] tail_instr, tail_pc;
   logic [31:0] target;
   logic        pop;
   logic        fetch;

   assign target    = redirect_pc & ~32'h3;
   assign out_valid = (count != 2'd0);
   assign pop       = out_valid & out_ready;
   // A pop frees a slot in the same cycle, so a full queue can still fetch.
   assign fetch     = (state == RUN) & ~redirect & ~halt & ((count < 2'd2) | pop);
   assign rom_sel   = fetch & rst_n;
   assign rom_addr  = pc[ADDR_BITS+1:2];
   assign out_instr = head_instr;
   assign out_pc    = head_pc;
   assign halted    = (state == HALTED);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RUN;
         pc         <= RESET_PC;
         count      <= 2'd0;
         head_instr <= 32'd0;
         head_pc    <= 32'd0;
         tail_instr <= 32'd0;
         tail_pc    <= 32'd0;
      end else if (redirect) begin
         state <= RUN;
         pc    <= target;
         count <= 2'd0;
      end else begin
         if (state == RUN && halt)
            state <= HALTED;
         if (fetch)
            pc <= pc + 32'd4;
         // Head holds its value when the queue empties so outputs never go unknown.
         case ({fetch, pop})
            2'b10: begin
               if (count == 2'd0) begin
                  head_instr <= rom_dout;
                  head_pc    <= pc;
               end else begin
                  tail_instr <= rom_dout;
                  tail_pc    <= pc;
               end
               count <= count + 2'd1;
            end
            2'b01: begin
               if (count == 2'd2) begin
                  head_instr <= tail_instr;
                  head_pc    <= tail_pc;
               end
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd2) begin
                  head_instr <= tail_instr;
                  head_pc    <= tail_pc;
                  tail_instr <= rom_dout;
                  tail_pc    <= pc;
               end else begin
                  head_instr <= rom_dout;
                  head_pc    <= pc;
               end
            end
            default: ;
         endcase
      end
   end

   count_in_range: assert property (@(posedge clk) disable iff (!rst_n) count != 2'd3);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a behavioural ROM feeds the unit and
// every observed output is compared against hand-computed values.
module tb_instr_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic [3:0]  rom_addr;
   logic        rom_sel;
   logic [31:0] rom_dout;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        halted;

   int checks;
   int errors;

   instr_fetch_unit #(.ADDR_BITS(4), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_sel(rom_sel),
      .rom_dout(rom_dout), .redirect(redirect), .redirect_pc(redirect_pc),
      .halt(halt), .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc), .halted(halted)
   );

   function automatic logic [31:0] romWord(input logic [3:0] a);
      return 32'hC0DE_0000 | {20'h0, a, a, a};
   endfunction

   assign rom_dout = romWord(rom_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Drives one cycle's inputs just after the falling edge, leaving time for outputs to settle.
   task automatic applyStimulus(input logic rdy, input logic rdr, input logic [31:0] rpc, input logic hlt);
      @(negedge clk);
      rst_n       = 1'b1;
      out_ready   = rdy;
      redirect    = rdr;
      redirect_pc = rpc;
      halt        = hlt;
      #1;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n     = 1'b0;
      out_ready = 1'b0;
      redirect  = 1'b0;
      halt      = 1'b0;
      @(negedge clk);
   endtask

   task automatic checkHead(input string tag, input logic [31:0] pc);
      checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, "_pc"}, out_pc, pc);
      checkOutput({tag, "_instr"}, out_instr, romWord(pc[5:2]));
   endtask

   initial begin
      logic [31:0] p;
      checks      = 0;
      errors      = 0;
      rst_n       = 1'b0;
      out_ready   = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      halt        = 1'b0;

      repeat (2) @(negedge clk);
      #1;
      checkOutput("rst_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_instr", out_instr, 32'd0);
      checkOutput("rst_pc", out_pc, 32'd0);
      checkOutput("rst_halted", 32'(halted), 32'd0);
      checkOutput("rst_sel", 32'(rom_sel), 32'd0);
      checkOutput("rst_addr", 32'(rom_addr), 32'd0);

      // Streaming from reset with decode always ready.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
         checkOutput("stream_sel", 32'(rom_sel), 32'd1);
         checkOutput("stream_addr", 32'(rom_addr), 32'(i));
         if (i > 0)
            checkHead("stream", 32'(4 * (i - 1)));
         else
            checkOutput("stream_first_valid", 32'(out_valid), 32'd0);
      end

      // Asynchronous reset mid-stream at pc=0x14.
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      checkOutput("mid_addr", 32'(rom_addr), 32'd5);
      checkHead("mid", 32'h10);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_valid", 32'(out_valid), 32'd0);
      checkOutput("async_sel", 32'(rom_sel), 32'd0);
      checkOutput("async_pc", out_pc, 32'd0);
      @(negedge clk);

      // Back-pressure: only two fetches complete while decode stalls.
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
         checkOutput("stall_sel", 32'(rom_sel), (k < 2) ? 32'd1 : 32'd0);
         checkOutput("stall_addr", 32'(rom_addr), (k < 2) ? 32'(k) : 32'd2);
         if (k > 0)
            checkHead("stall", 32'h0);
      end

      // Halt with two entries queued: drain, then stay halted until redirect.
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      checkHead("halt_d0", 32'h0);
      checkOutput("halt_sel0", 32'(rom_sel), 32'd0);
      checkOutput("halt_h0", 32'(halted), 32'd0);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      checkHead("halt_d1", 32'h4);
      checkOutput("halt_h1", 32'(halted), 32'd1);
      checkOutput("halt_sel1", 32'(rom_sel), 32'd0);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      checkOutput("halt_empty", 32'(out_valid), 32'd0);
      checkOutput("halt_h2", 32'(halted), 32'd1);
      checkOutput("halt_sel2", 32'(rom_sel), 32'd0);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      checkOutput("halt_h3", 32'(halted), 32'd1);
      checkOutput("halt_sel3", 32'(rom_sel), 32'd0);
      applyStimulus(1'b1, 1'b1, 32'h0, 1'b0);
      checkOutput("unhalt_sel", 32'(rom_sel), 32'd0);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      checkOutput("unhalt_h", 32'(halted), 32'd0);
      checkOutput("unhalt_valid", 32'(out_valid), 32'd0);
      checkOutput("unhalt_sel1", 32'(rom_sel), 32'd1);
      checkOutput("unhalt_addr", 32'(rom_addr), 32'd0);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      checkHead("unhalt", 32'h0);

      // Stall then release: no bubble when decode becomes ready.
      doReset();
      repeat (5) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      for (int a = 0; a < 3; a++) begin
         applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
         checkHead("release", 32'(4 * a));
         checkOutput("release_sel", 32'(rom_sel), 32'd1);
      end

      // Redirect with a full queue to an unaligned target.
      applyStimulus(1'b0, 1'b1, 32'h0000_0026, 1'b0);
      checkHead("redir_before", 32'hC);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("redir_valid", 32'(out_valid), 32'd0);
      checkOutput("redir_addr", 32'(rom_addr), 32'd9);
      checkOutput("redir_sel", 32'(rom_sel), 32'd1);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      checkHead("redir_target", 32'h24);

      // Halt and redirect together: redirect wins.
      applyStimulus(1'b1, 1'b1, 32'h10, 1'b1);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      checkOutput("hr_halted", 32'(halted), 32'd0);
      checkOutput("hr_valid", 32'(out_valid), 32'd0);
      checkOutput("hr_addr", 32'(rom_addr), 32'd4);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      checkHead("hr", 32'h10);
      checkOutput("hr_halted1", 32'(halted), 32'd0);

      // Run across pc=0x40 where the 4-bit ROM address wraps.
      for (int j = 1; j <= 12; j++) begin
         applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
         p = 32'h14 + 32'(4 * j);
         checkOutput("wrap_addr", 32'(rom_addr), 32'(p[5:2]));
         checkHead("wrap", 32'h10 + 32'(4 * j));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
